// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
//   Shared types for the convolution pipeline.
//   - kernel_pos_t        : boundary flags for one kernel-centre pixel; the
//                           zero-pad masking stage uses them to decide which
//                           taps fall outside the image.
//   - kernel_pos_marker_t : frame markers travelling with each position.
//   - sched_state_t       : frame-level states of the raster scheduler.
//   - DEFAULT_IMG_*_MAX   : default maximum image dimensions.
//   - sizeLegal()         : range check for a configured image dimension.
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int DEFAULT_IMG_W_MAX = 1024;
    localparam int DEFAULT_IMG_H_MAX = 1024;

    // n = north (top), s = south (bottom), e = east (right), w = west (left).
    // The "2" flag means the pixel sits on the outermost row/column, the "1"
    // flag means it is one row/column in from that edge.
    typedef struct packed {
        logic n1;
        logic n2;
        logic s1;
        logic s2;
        logic e1;
        logic e2;
        logic w1;
        logic w2;
    } kernel_pos_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } kernel_pos_marker_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    // A dimension is usable when it is at least one pixel and no larger than
    // the maximum the buffers were sized for.
    function automatic logic sizeLegal(input int size, input int maxSize);
        return (size != 0) && (size <= maxSize);
    endfunction

endpackage

// File: rtl/conv_raster_cnt.sv
// ---------------------------------------------------------------------------
// conv_raster_cnt
//   Column/row raster counters for the kernel position scheduler. The
//   counters hold the coordinate of the next token to be accepted.
//
//   Ports:
//     clk, rst     : clock, asynchronous active-high reset
//     clear_i      : return both counters to (0,0)
//     advance_i    : step to the next raster position
//     width_i      : image width W (>= 1 while counting)
//     height_i     : image height H (>= 1 while counting)
//     col_o, row_o : current column / row
//     colLast_o    : current column is W-1
//     rowLast_o    : current row is H-1
//     atLast_o     : current position is the last pixel (H-1,W-1)
// ---------------------------------------------------------------------------
module conv_raster_cnt
    import conv_pkg::*;
#(
    parameter int COL_W = 11,
    parameter int ROW_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             advance_i,
    input  logic [COL_W-1:0] width_i,
    input  logic [ROW_W-1:0] height_i,
    output logic [COL_W-1:0] col_o,
    output logic [ROW_W-1:0] row_o,
    output logic             colLast_o,
    output logic             rowLast_o,
    output logic             atLast_o
);

    logic [COL_W-1:0] col_q;
    logic [COL_W-1:0] col_d;
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] row_d;

    // Edge detection against the configured size. The subtraction is safe
    // because the scheduler only counts with W,H >= 1.
    assign colLast_o = (col_q == (width_i - COL_W'(1)));
    assign rowLast_o = (row_q == (height_i - ROW_W'(1)));
    assign atLast_o  = colLast_o & rowLast_o;
    assign col_o     = col_q;
    assign row_o     = row_q;

    // Next raster position: clear wins over advance; the column wraps at the
    // end of a line and carries into the row. The row is never wrapped here
    // because the scheduler stops accepting tokens after the last pixel.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = '0;
            row_d = '0;
        end else if (advance_i) begin
            if (colLast_o) begin
                col_d = '0;
                row_d = row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/conv_kernel_pos_sched.sv
// ---------------------------------------------------------------------------
// conv_kernel_pos_sched
//   Raster-scan scheduler for the zero-pad masking stage. For each accepted
//   kernel-centre token it emits the boundary flags of that pixel plus
//   frame markers, one register stage after the handshake. A frame is
//   configured in IDLE, streamed in RUN and closed by a one-cycle DONE.
//   Upstream end-of-line markers are cross-checked against the own count.
//
//   Ports:
//     clk, rst        : clock, asynchronous active-high reset
//     cfg_start_i     : start-of-frame request (only seen in IDLE)
//     cfg_width_i     : image width W, 1..IMG_W_MAX
//     cfg_height_i    : image height H, 1..IMG_H_MAX
//     cfg_abort_i     : abandon the frame and return to IDLE
//     busy_o          : high while in RUN
//     done_o          : high for the single DONE cycle
//     err_o           : sticky error (bad size or EOL mismatch)
//     in_valid_i      : kernel-centre token valid
//     in_eol_i        : upstream end-of-line marker for the token
//     in_ready_o      : token accepted when in_valid_i & in_ready_o
//     pos_valid_o     : position output valid
//     pos_ready_i     : downstream ready
//     pos_o           : boundary flags of the current centre pixel
//     pos_sof_o       : first pixel of the frame
//     pos_eol_o       : last column of a line
//     pos_eof_o       : last pixel of the frame
// ---------------------------------------------------------------------------
module conv_kernel_pos_sched
    import conv_pkg::*;
#(
    parameter int IMG_W_MAX = DEFAULT_IMG_W_MAX,
    parameter int IMG_H_MAX = DEFAULT_IMG_H_MAX,
    localparam int COL_W    = $clog2(IMG_W_MAX + 1),
    localparam int ROW_W    = $clog2(IMG_H_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_start_i,
    input  logic [COL_W-1:0] cfg_width_i,
    input  logic [ROW_W-1:0] cfg_height_i,
    input  logic             cfg_abort_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    input  logic             in_valid_i,
    input  logic             in_eol_i,
    output logic             in_ready_o,
    output logic             pos_valid_o,
    input  logic             pos_ready_i,
    output kernel_pos_t      pos_o,
    output logic             pos_sof_o,
    output logic             pos_eol_o,
    output logic             pos_eof_o
);

    sched_state_t       state_q;
    sched_state_t       state_d;
    logic [COL_W-1:0]   width_q;
    logic [COL_W-1:0]   width_d;
    logic [ROW_W-1:0]   height_q;
    logic [ROW_W-1:0]   height_d;
    logic               lastTaken_q;
    logic               lastTaken_d;
    logic               err_q;
    logic               err_d;
    logic               posValid_q;
    logic               posValid_d;
    kernel_pos_t        pos_q;
    kernel_pos_t        pos_d;
    kernel_pos_marker_t marker_q;
    kernel_pos_marker_t marker_d;

    logic               startLegal;
    logic               startAccept;
    logic               startReject;
    logic               tokenAccept;
    logic               posHandshake;
    logic               cntClear;
    logic [COL_W-1:0]   cntCol;
    logic [ROW_W-1:0]   cntRow;
    logic               colLast;
    logic               rowLast;
    logic               atLast;
    kernel_pos_t        decodedPos;
    kernel_pos_marker_t decodedMarker;

    // Raster counters hold the coordinate the next accepted token gets.
    // They are reset by an abort or by a freshly accepted start.
    conv_raster_cnt #(
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_raster_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (cntClear),
        .advance_i (tokenAccept),
        .width_i   (width_q),
        .height_i  (height_q),
        .col_o     (cntCol),
        .row_o     (cntRow),
        .colLast_o (colLast),
        .rowLast_o (rowLast),
        .atLast_o  (atLast)
    );

    // Handshake qualifiers. Abort overrides both a start and a token
    // handshake in the same cycle, so it gates every "accept" term here.
    // The output register can take a new token when it is empty or being
    // drained this cycle, which gives one token per cycle at full rate.
    always_comb begin
        startLegal   = sizeLegal(32'(cfg_width_i), IMG_W_MAX) &&
                       sizeLegal(32'(cfg_height_i), IMG_H_MAX);
        startAccept  = ~cfg_abort_i & (state_q == IDLE) & cfg_start_i & startLegal;
        startReject  = ~cfg_abort_i & (state_q == IDLE) & cfg_start_i & ~startLegal;
        in_ready_o   = (state_q == RUN) & ~lastTaken_q & (~posValid_q | pos_ready_i);
        tokenAccept  = in_valid_i & in_ready_o & ~cfg_abort_i;
        posHandshake = posValid_q & pos_ready_i;
        cntClear     = cfg_abort_i | startAccept;
    end

    // Boundary flag decode for the coordinate about to be accepted. Each
    // flag is an independent equality test, so tiny images naturally set
    // several flags at once (W=1 gives w2 and e2 together). The "one in
    // from the far edge" flags need at least two rows/columns to exist.
    always_comb begin
        decodedPos        = '0;
        decodedPos.n2     = (cntRow == ROW_W'(0));
        decodedPos.n1     = (cntRow == ROW_W'(1));
        decodedPos.s2     = rowLast;
        decodedPos.s1     = (height_q >= ROW_W'(2)) && (cntRow == (height_q - ROW_W'(2)));
        decodedPos.w2     = (cntCol == COL_W'(0));
        decodedPos.w1     = (cntCol == COL_W'(1));
        decodedPos.e2     = colLast;
        decodedPos.e1     = (width_q >= COL_W'(2)) && (cntCol == (width_q - COL_W'(2)));
        decodedMarker     = '0;
        decodedMarker.sof = (cntRow == ROW_W'(0)) && (cntCol == COL_W'(0));
        decodedMarker.eol = colLast;
        decodedMarker.eof = colLast & rowLast;
    end

    // Frame-level next state. RUN only closes when the last position has
    // actually left the output register, so DONE marks true completion
    // downstream. DONE always falls back to IDLE after one cycle.
    always_comb begin
        state_d = state_q;
        if (cfg_abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (startAccept) state_d = RUN;
                RUN:     if (lastTaken_q && posHandshake) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Datapath next values. The size is latched only on an accepted start.
    // The error flag is cleared by a good start, set by a rejected start or
    // an upstream EOL that disagrees with our own column count, and simply
    // held through an abort. Once the last pixel is taken no more tokens
    // are admitted until the next start. The output register keeps its
    // contents whenever nothing new is loaded, so a stalled position stays
    // stable for the downstream stage.
    always_comb begin
        width_d     = width_q;
        height_d    = height_q;
        lastTaken_d = lastTaken_q;
        err_d       = err_q;
        posValid_d  = posValid_q;
        pos_d       = pos_q;
        marker_d    = marker_q;

        if (startAccept) begin
            width_d  = cfg_width_i;
            height_d = cfg_height_i;
        end

        if (cntClear) begin
            lastTaken_d = 1'b0;
        end else if (tokenAccept && atLast) begin
            lastTaken_d = 1'b1;
        end

        if (startAccept) begin
            err_d = 1'b0;
        end else if (startReject) begin
            err_d = 1'b1;
        end else if (tokenAccept && (in_eol_i != colLast)) begin
            err_d = 1'b1;
        end

        if (cfg_abort_i) begin
            posValid_d = 1'b0;
        end else if (tokenAccept) begin
            posValid_d = 1'b1;
            pos_d      = decodedPos;
            marker_d   = decodedMarker;
        end else if (posHandshake) begin
            posValid_d = 1'b0;
        end
    end

    // State and datapath registers; a reset mid-frame drops everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            width_q     <= '0;
            height_q    <= '0;
            lastTaken_q <= 1'b0;
            err_q       <= 1'b0;
            posValid_q  <= 1'b0;
            pos_q       <= '0;
            marker_q    <= '0;
        end else begin
            state_q     <= state_d;
            width_q     <= width_d;
            height_q    <= height_d;
            lastTaken_q <= lastTaken_d;
            err_q       <= err_d;
            posValid_q  <= posValid_d;
            pos_q       <= pos_d;
            marker_q    <= marker_d;
        end
    end

    // Registered outputs straight from the state and output stage.
    assign busy_o      = (state_q == RUN);
    assign done_o      = (state_q == DONE);
    assign err_o       = err_q;
    assign pos_valid_o = posValid_q;
    assign pos_o       = pos_q;
    assign pos_sof_o   = marker_q.sof;
    assign pos_eol_o   = marker_q.eol;
    assign pos_eof_o   = marker_q.eof;

endmodule
